multiword_add_seq: RTL and testbench



---
 rtl/multiword_add_seq.sv | 155 +++++++++++++++
 tb/tb_multiword_add_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/multiword_add_seq.sv
// Sequential WIDTH-bit adder/subtractor that reuses one 4-bit ripple slice,
// one nibble per clock, least-significant nibble first, with start/busy/done handshake.

module fourbit_adder (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);

  logic [4:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign o_sum[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i + 1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_cout = w_c[4];

endmodule

module multiword_add_seq #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
    $error("multiword_add_seq: WIDTH must be a multiple of 4 and at least 8");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic             r_carry;
  logic [WIDTH-5:0] r_shadow;
  logic             r_sign_a;
  logic             r_sign_b;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [3:0]       w_slice_sum;
  logic             w_slice_cout;
  logic [WIDTH-1:0] w_result;

  fourbit_adder u_slice (
    .i_a    (r_op_a[3:0]),
    .i_b    (r_op_b[3:0]),
    .i_cin  (r_carry),
    .o_sum  (w_slice_sum),
    .o_cout (w_slice_cout)
  );

  // The shadow keeps only the N-1 finished nibbles; the live slice output
  // supplies the top nibble, so the full word is ready on the last RUN cycle.
  assign w_result = {w_slice_sum, r_shadow};

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values; the synchronous reset clears datapath registers too.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_carry  <= 1'b0;
      r_shadow <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_op_a   <= i_a;
            r_op_b   <= i_sub ? ~i_b : i_b;
            r_carry  <= i_sub ? ~i_cin : i_cin;
            r_sign_a <= i_a[WIDTH-1];
            r_sign_b <= i_sub ? ~i_b[WIDTH-1] : i_b[WIDTH-1];
            r_cnt    <= '0;
            r_shadow <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end
        end

        S_RUN: begin
          r_shadow <= w_result[WIDTH-1:4];
          r_op_a   <= r_op_a >> 4;
          r_op_b   <= r_op_b >> 4;
          r_carry  <= w_slice_cout;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_sum   <= w_result;
            r_cout  <= w_slice_cout;
            r_ovf   <= (r_sign_a == r_sign_b) && (w_slice_sum[3] != r_sign_a);
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_sum  = r_sum;
  assign o_cout = r_cout;
  assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed bench for multiword_add_seq (WIDTH=16): a transaction-level model
// compared every cycle, plus literal expectations per directed vector.

module tb_multiword_add_seq;

  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 4;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } result_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;

  multiword_add_seq #(.WIDTH(WIDTH)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_sub   (sub),
    .i_a     (a),
    .i_b     (b),
    .i_cin   (cin),
    .o_busy  (busy),
    .o_done  (done),
    .o_sum   (sum),
    .o_cout  (cout),
    .o_ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Plain integer arithmetic: unsigned result for sum/cout, signed range for ovf.
  function automatic result_t model(input logic [WIDTH-1:0] fa, input logic [WIDTH-1:0] fb,
                                    input logic fc, input logic fs);
    result_t r;
    int u, sv, sa, sb, c;
    sa = $signed(fa);
    sb = $signed(fb);
    c  = fc ? 1 : 0;
    if (!fs) begin
      u  = int'(fa) + int'(fb) + c;
      sv = sa + sb + c;
    end else begin
      u  = int'(fa) + 65536 - int'(fb) - c;
      sv = sa - sb - c;
    end
    r.sum  = u[WIDTH-1:0];
    r.cout = u[WIDTH];
    r.ovf  = (sv > 32767) || (sv < -32768);
    return r;
  endfunction

  // Model timing: m_left counts cycles left in the busy window; done is its last cycle.
  int      m_left;
  result_t m_pend;
  result_t m_out;

  always @(posedge clk) begin
    if (rst) begin
      m_left <= 0;
      m_out  <= '0;
    end else if (m_left == 0) begin
      if (start) begin
        m_pend <= model(a, b, cin, sub);
        m_left <= N + 1;
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 2) m_out <= m_pend;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", busy, m_left != 0);
      check("cyc_done", done, m_left == 1);
      check("cyc_sum",  sum,  m_out.sum);
      check("cyc_cout", cout, m_out.cout);
      check("cyc_ovf",  ovf,  m_out.ovf);
    end
  end

  task automatic run_op(input string name, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                        input logic vc, input logic vs, input logic [WIDTH-1:0] e_sum,
                        input logic e_cout, input logic e_ovf);
    int cyc;
    @(negedge clk);
    a = va; b = vb; cin = vc; sub = vs; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy"}, busy, 1'b1);
    cyc = 1;
    while (done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_latency"}, cyc, N + 1);
    check({name, "_sum"}, sum, e_sum);
    check({name, "_cout"}, cout, e_cout);
    check({name, "_ovf"}, ovf, e_ovf);
    @(negedge clk);
    check({name, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    int cyc;
    int n_done;
    rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;

    // Reset for two cycles, then idle.
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("idle_busy", busy, 1'b0);
    check("idle_sum", sum, 16'h0000);

    run_op("add_basic",  16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("sub_borrow", 16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    run_op("sub_cin",    16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);
    run_op("add_cin",    16'h00FF, 16'h0F00, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);

    // Start pulses during RUN and DONE must be ignored.
    @(negedge clk);
    a = 16'h0001; b = 16'h0001; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 3;
    while (done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("ign_latency", cyc, N + 1);
    check("ign_sum", sum, 16'h0002);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ign_idle", busy, 1'b0);
    n_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    check("ign_no_done", n_done, 0);
    check("ign_sum_hold", sum, 16'h0002);

    // Reset in the second RUN cycle aborts without a done pulse.
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_sum", sum, 16'h0000);
    check("abort_cout", cout, 1'b0);
    n_done = 0;
    repeat (8) begin
      if (done === 1'b1) n_done++;
      @(negedge clk);
    end
    check("abort_no_done", n_done, 0);
    run_op("after_abort", 16'hAAAA, 16'h5555, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0);

    // Start held high: back-to-back operations every N+2 cycles.
    @(negedge clk);
    a = 16'h0010; b = 16'h0020; sub = 1'b0; cin = 1'b0; start = 1'b1;
    n_done = 0;
    repeat (3 * (N + 2)) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    start = 1'b0;
    check("held_done_count", n_done, 3);
    check("held_sum", sum, 16'h0030);
    repeat (N + 3) @(negedge clk);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
